// File: rtl/sram_client_pkg.sv
// Shared definitions for the single-port SRAM requester: default geometry,
// arbiter priority encoding and the per-cycle grant decision type.
package sram_client_pkg;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 76;
  localparam int DEF_QDEPTH = 3;

  // Arbiter priority register encoding: which side wins a contested cycle.
  localparam logic PRIO_WRITE = 1'b0;
  localparam logic PRIO_READ  = 1'b1;

  // Owner of the RW0 port in the current cycle.
  typedef enum logic [1:0] {
    GRANT_NONE  = 2'd0,
    GRANT_WRITE = 2'd1,
    GRANT_READ  = 2'd2
  } grant_e;

endpackage

// File: rtl/sram_resp_fifo.sv
// Read-response queue: DEPTH x DATA_W circular buffer with explicit pointer
// wrap so that non-power-of-two depths work. Enqueue and dequeue may happen
// in the same cycle. The caller guarantees no enqueue when full and no
// dequeue when empty (credit check and valid gating in the top).
module sram_resp_fifo #(
  parameter int DEPTH  = 3,
  parameter int DATA_W = 76,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enq_i,
  input  logic [DATA_W-1:0] enq_data_i,
  input  logic              deq_i,
  output logic [DATA_W-1:0] deq_data_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Advance a pointer, wrapping at DEPTH-1 rather than at a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = enq_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = deq_i ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    unique case ({enq_i, deq_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Payload storage written at the tail.
  // NOTE: storage is deliberately not reset; only pointers and count define
  // which entries are live, and leaving data unreset lets it map to plain
  // flops/RAM without a reset tree.
  always_ff @(posedge clock) begin
    if (enq_i) begin
      mem_q[wr_ptr_q] <= enq_data_i;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign deq_data_o = mem_q[rd_ptr_q];
  assign valid_o    = (count_q != '0);
  assign count_o    = count_q;

endmodule

// File: rtl/sram_sp_client.sv
// Requester-side controller for a single-port (RW0) SRAM macro. Arbitrates
// independent write and read request streams onto the one port, tracks the
// macro's one-cycle read latency and returns read data, oldest first,
// through a small response queue. Reads are only granted while the queue
// has a guaranteed slot (occupancy + in-flight < QDEPTH), so the capture
// of sram_rdata never needs to stall.
module sram_sp_client
  import sram_client_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int QDEPTH = DEF_QDEPTH   // legal 2..8; >= 3 for one read/cycle
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_w_valid,
  output logic              io_w_ready,
  input  logic [ADDR_W-1:0] io_w_addr,
  input  logic [DATA_W-1:0] io_w_data,
  input  logic              io_r_valid,
  output logic              io_r_ready,
  input  logic [ADDR_W-1:0] io_r_addr,
  output logic              io_resp_valid,
  input  logic              io_resp_ready,
  output logic [DATA_W-1:0] io_resp_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int CNT_W = $clog2(QDEPTH + 1);

  logic [CNT_W-1:0] occupancy;
  logic [CNT_W:0]   credit_used;
  logic             read_eligible;
  logic             contested;
  logic             inflight_q, inflight_d;
  logic             prio_q, prio_d;
  grant_e           grant;

  // Credit check deliberately ignores a same-cycle dequeue so that
  // io_r_ready never depends combinationally on io_resp_ready.
  assign credit_used   = {1'b0, occupancy} + {{CNT_W{1'b0}}, inflight_q};
  assign read_eligible = io_r_valid && (credit_used < (CNT_W + 1)'(QDEPTH));
  assign contested     = io_w_valid && read_eligible;

  // Pick the owner of the RW0 port for this cycle.
  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    grant = GRANT_NONE;
    if (contested) begin
      grant = (prio_q == PRIO_READ) ? GRANT_READ : GRANT_WRITE;
    end else if (io_w_valid) begin
      grant = GRANT_WRITE;
    end else if (read_eligible) begin
      grant = GRANT_READ;
    end
  end

  assign io_w_ready = (grant == GRANT_WRITE);
  assign io_r_ready = (grant == GRANT_READ);

  // Drive the macro port from the granted request; idle cycles drive zeros.
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    unique case (grant)
      GRANT_WRITE: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = io_w_addr;
        sram_wdata = io_w_data;
      end
      GRANT_READ: begin
        sram_en   = 1'b1;
        sram_addr = io_r_addr;
      end
      default: ;
    endcase
  end

  // Priority flips only when both sides actually competed for the port.
  assign prio_d     = contested ? ~prio_q : prio_q;
  assign inflight_d = (grant == GRANT_READ);

  // Arbiter priority and read-in-flight tracking.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio_q     <= PRIO_WRITE;
      inflight_q <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      inflight_q <= inflight_d;
    end
  end

  // The cycle after a read grant the macro presents its data; capture it.
  sram_resp_fifo #(
    .DEPTH  (QDEPTH),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_resp_fifo (
    .clock      (clock),
    .reset      (reset),
    .enq_i      (inflight_q),
    .enq_data_i (sram_rdata),
    .deq_i      (io_resp_valid && io_resp_ready),
    .deq_data_o (io_resp_data),
    .valid_o    (io_resp_valid),
    .count_o    (occupancy)
  );

endmodule
